// File: rtl/dual_port_ram_if.sv
// dual_port_ram_if: clear/busy handshake plus port A and port B buses; master drives requests, slave (the RAM) returns data
interface dual_port_ram_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic clear;
    logic busy;
    logic a_write_enable;
    logic [DATA_WIDTH/8-1:0] a_byte_enable;
    logic [ADDRESS_WIDTH-1:0] a_address;
    logic [DATA_WIDTH-1:0] a_in_data;
    logic [DATA_WIDTH-1:0] a_out_data;
    logic b_read_enable;
    logic [ADDRESS_WIDTH-1:0] b_address;
    logic [DATA_WIDTH-1:0] b_out_data;
    logic b_valid;
    modport master (
        output clear, a_write_enable, a_byte_enable, a_address, a_in_data, b_read_enable, b_address,
        input busy, a_out_data, b_out_data, b_valid
    );
    modport slave (
        input clear, a_write_enable, a_byte_enable, a_address, a_in_data, b_read_enable, b_address,
        output busy, a_out_data, b_out_data, b_valid
    );
endinterface

// File: rtl/dual_port_ram.sv
// dual_port_ram: byte-lane R/W port A, read-only port B with valid, sweep-to-zero clear engine; ports clk, reset (sync, active-high), bus (slave)
module dual_port_ram #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter bit READ_MODE = 1'b0
) (
    input logic clk,
    input logic reset,
    dual_port_ram_if.slave bus
);
    localparam int LANES = DATA_WIDTH / 8;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;
    logic [ADDRESS_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];
    logic a_write, clear_write;
    logic [DATA_WIDTH-1:0] merged, a_next, b_next;
    // a clear request in IDLE takes priority over a same-cycle port A write
    assign a_write = bus.a_write_enable && state == IDLE && !bus.clear;
    // reset aborts the sweep before the current word is touched
    assign clear_write = state == CLEAR && !reset;
    assign bus.busy = state == CLEAR;
    always_comb begin
        merged = mem[bus.a_address];
        for (int i = 0; i < LANES; i++)
            if (bus.a_byte_enable[i]) merged[8*i +: 8] = bus.a_in_data[8*i +: 8];
    end
    // contents of each read address as they will be after this edge (write-first view)
    assign a_next = clear_write && bus.a_address == count ? '0 : a_write ? merged : mem[bus.a_address];
    assign b_next = clear_write && bus.b_address == count ? '0 :
                    a_write && bus.b_address == bus.a_address ? merged : mem[bus.b_address];
    always_ff @(posedge clk) begin
        if (clear_write) mem[count] <= '0;
        else if (a_write) mem[bus.a_address] <= merged;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            bus.a_out_data <= '0;
            bus.b_out_data <= '0;
            bus.b_valid <= 1'b0;
        end else begin
            state <= state == IDLE ? (bus.clear ? CLEAR : IDLE) : (&count ? IDLE : CLEAR);
            count <= state == CLEAR ? count + 1'b1 : '0;
            bus.a_out_data <= READ_MODE ? a_next : mem[bus.a_address];
            if (bus.b_read_enable) bus.b_out_data <= READ_MODE ? b_next : mem[bus.b_address];
            bus.b_valid <= bus.b_read_enable;
        end
    end
endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
Parametrised synchronous RAM, successor to the single-port lab RAM. Provides:
- port A: read/write, with byte-lane write enables;
- port B: independent read-only port with a valid flag;
- a built-in clear engine that sweeps every word to zero.

Used as the shared data store between a producer (port A) and a consumer/monitor (port B) in the lab datapath.

Parameters:
- ADDRESS_WIDTH, 5, address bits per port; DATA_DEPTH = 2**ADDRESS_WIDTH words.
- DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
- READ_MODE, 0, same-address read-during-write: 0 = read-first (old data), 1 = write-first (new data).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  pulse; starts a zeroing sweep of the whole memory.
- busy  output  1  high while the clear sweep runs.
- a_write_enable  input  1  port A write request.
- a_byte_enable  input  DATA_WIDTH/8  lane mask; bit i covers a_in_data[8i+7:8i].
- a_address  input  ADDRESS_WIDTH  port A address.
- a_in_data  input  DATA_WIDTH  port A write data.
- a_out_data  output  DATA_WIDTH  port A registered read data.
- b_read_enable  input  1  port B read request.
- b_address  input  ADDRESS_WIDTH  port B address.
- b_out_data  output  DATA_WIDTH  port B registered read data.
- b_valid  output  1  b_out_data holds data for a request made the previous cycle.

Behaviour:
- Reset (sampled at the clk edge):
  - a_out_data=0, b_out_data=0, b_valid=0, busy=0, FSM to IDLE, clear counter=0.
  - Memory contents are not altered by reset.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR: on clear=1. busy=1 from the next cycle.
  - In CLEAR: one word is zeroed per cycle, counter 0 to DATA_DEPTH-1 in ascending order.
  - After word DATA_DEPTH-1 is written: go to IDLE, busy=0 on the following cycle. busy is high for exactly DATA_DEPTH cycles.
  - clear while in CLEAR: ignored, no restart.
  - reset mid-sweep: abort to IDLE. Words already zeroed stay zero; the rest keep old data.
- Port A write:
  - Occurs when a_write_enable=1 and busy=0 and FSM is not entering CLEAR (clear=1 in IDLE suppresses the write that cycle).
  - Only lanes with a_byte_enable[i]=1 are updated.
  - a_write_enable with all-zero mask: no change.
  - Writes while busy=1 are dropped silently.
- Port A read:
  - a_out_data <= mem[a_address] every cycle (1-cycle latency), including while busy. It may return partially cleared contents.
  - Same-cycle write to the same address: READ_MODE=0 returns the old word; READ_MODE=1 returns the merged new word (written lanes new, others old).
- Port B read:
  - b_read_enable=1: b_out_data <= mem[b_address]; b_valid=1 next cycle.
  - b_read_enable=0: b_out_data holds; b_valid=0 next cycle.
  - b_address equal to a port A write address in the same cycle follows READ_MODE, as for port A.
  - During CLEAR, b_address equal to the word being cleared in that cycle returns old (mode 0) or zero (mode 1).
- Addresses wrap naturally; there are no out-of-range accesses.
- No X on any output after the first reset.

Test Plan (DATA_WIDTH=16, ADDRESS_WIDTH=5 unless stated):
1. Reset then clear pulse:
   - busy=1 for 32 cycles.
   - Then read all addresses on port B → every b_out_data=16'h0000, b_valid=1 one cycle after each request.
2. Fill and read: write mem[i]=i*3 for i=0..31 with a_byte_enable=2'b11 → port A read of addr 10 gives 16'd30 next cycle; port B read of addr 31 gives 16'd93.
3. Byte lanes:
   - Write 16'hABCD to addr 4 with mask 2'b11.
   - Then write 16'h1234 with mask 2'b01 → read gives 16'hAB34.
   - Then mask 2'b00 → still 16'hAB34.
4. Read-during-write: addr 7 holds 16'h0011; write 16'h2200 mask 2'b10 while port B reads addr 7 →
   - READ_MODE=0: b_out_data=16'h0011;
   - READ_MODE=1: b_out_data=16'h2211;
   - mem[7]=16'h2211 afterwards in both modes.
5. Writes blocked while busy: start clear, attempt to write 16'hFFFF to addr 31 on cycle 3 of the sweep → after busy falls, mem[31]=0. A second clear pulse mid-sweep does not extend busy beyond 32 cycles.
6. Reset mid-sweep:
   - Preload all words with 16'h5555, clear, assert reset on sweep cycle 10 → busy=0 and outputs 0 next cycle.
   - Addresses 0..9 read 0; addresses 10..31 read 16'h5555.
